// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares one single-port synchronous RAM between instruction fetch
//             and load/store, data-priority with bounded fetch starvation.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [3:0]        d_wstrb,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,

    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    localparam int                    c_STREAK_W   = $clog2(MAX_DATA_BURST) + 1;
    localparam logic [c_STREAK_W-1:0] c_STREAK_MAX = c_STREAK_W'(MAX_DATA_BURST);
    localparam logic                  c_OWNER_IF   = 1'b0;
    localparam logic                  c_OWNER_D    = 1'b1;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t                r_state;
    logic                  r_owner;
    logic                  r_store;
    logic                  r_if_ack;
    logic                  r_d_ack;
    logic [c_STREAK_W-1:0] r_streak;

    logic w_idle;
    logic w_grant_d;
    logic w_grant_if;
    logic w_grant;
    logic w_store;
    logic w_unused;

    // Byte offsets never reach the RAM; alignment belongs to the core.
    assign w_unused = ^{if_addr[1:0], d_addr[1:0]};

    // Reset masks the grant so a store presented during reset never writes.
    assign w_idle     = (r_state == S_IDLE) && !rst;
    assign w_grant_d  = w_idle && d_req && (!if_req || (r_streak != c_STREAK_MAX));
    assign w_grant_if = w_idle && if_req && !w_grant_d;
    assign w_grant    = w_grant_d || w_grant_if;
    assign w_store    = w_grant_d && d_we;

    // RAM request side: driven straight from the winner, no mem_rdata in the cone.
    assign mem_en    = w_grant;
    assign mem_addr  = w_grant_d  ? d_addr[ADDR_W-1:2]  :
                       w_grant_if ? if_addr[ADDR_W-1:2] : '0;
    assign mem_we    = w_store ? d_wstrb : 4'b0000;
    assign mem_wdata = w_store ? d_wdata : '0;

    // Response side: acks come from registered owner flags, squashed by reset.
    assign if_ack   = r_if_ack && !rst;
    assign d_ack    = r_d_ack && !rst;
    assign busy     = (r_state == S_RESP) && !rst;
    assign if_rdata = if_ack ? mem_rdata : '0;
    assign d_rdata  = (d_ack && !r_store) ? mem_rdata : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_owner  <= c_OWNER_IF;
            r_store  <= 1'b0;
            r_if_ack <= 1'b0;
            r_d_ack  <= 1'b0;
            r_streak <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_state  <= S_RESP;
                        r_owner  <= w_grant_d ? c_OWNER_D : c_OWNER_IF;
                        r_store  <= w_store;
                        r_if_ack <= w_grant_if;
                        r_d_ack  <= w_grant_d;
                        // Only data wins over a waiting fetch count toward the burst limit.
                        if (w_grant_d && if_req) begin
                            if (r_streak != c_STREAK_MAX) begin
                                r_streak <= r_streak + c_STREAK_W'(1);
                            end
                        end else begin
                            r_streak <= '0;
                        end
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_store  <= 1'b0;
                    r_if_ack <= 1'b0;
                    r_d_ack  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Self-checking bench for mem_arbiter with a behavioural RAM.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W         = 32;
    localparam int DATA_W         = 32;
    localparam int MAX_DATA_BURST = 4;
    localparam int RAM_WORDS      = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_wstrb;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-3:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .MAX_DATA_BURST (MAX_DATA_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ack     (d_ack),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 0) ? 32'h0050_0093 : (32'h1000_0000 | 32'(i));
    endfunction

    // Behavioural single-port RAM: byte-write, registered read.
    logic [31:0] ram [RAM_WORDS];
    logic        ram_init;
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < RAM_WORDS; i++) ram[i] <= init_word(i);
            mem_rdata <= '0;
        end else if (mem_en) begin
            for (int b = 0; b < 4; b++)
                if (mem_we[b]) ram[mem_addr[7:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          fetch;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    // One isolated transaction; called at a post-edge instant of an IDLE cycle.
    task automatic do_txn(input vec_t v, input int k);
        bit wr;
        wr = !v.fetch && v.we;
        if (v.fetch) begin
            if_req = 1'b1; if_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wstrb = v.strb;
        end
        @(negedge clk);
        chk($sformatf("v%0d_mem_en", k),    32'(mem_en), 32'd1);
        chk($sformatf("v%0d_mem_addr", k),  32'(mem_addr), v.addr >> 2);
        chk($sformatf("v%0d_mem_we", k),    32'(mem_we), wr ? 32'(v.strb) : 32'd0);
        chk($sformatf("v%0d_mem_wdata", k), mem_wdata, wr ? v.wdata : 32'd0);
        step();
        @(negedge clk);
        chk($sformatf("v%0d_if_ack", k), 32'(if_ack), v.fetch ? 32'd1 : 32'd0);
        chk($sformatf("v%0d_d_ack", k),  32'(d_ack),  v.fetch ? 32'd0 : 32'd1);
        chk($sformatf("v%0d_rdata", k),  v.fetch ? if_rdata : d_rdata, v.exp_rdata);
        step();
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);
        chk($sformatf("v%0d_idle_en", k), 32'(mem_en), 32'd0);
        step();
    endtask

    string order;
    int    if_cycles[$];

    // Both requesters held continuously; records which side wins each grant.
    task automatic run_contention(input int n);
        int cyc;
        cyc   = 0;
        order = "";
        if_cycles.delete();
        if_req = 1'b1; if_addr = 32'h10;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h200;
        while (order.len() < n && cyc < 8 * n) begin
            @(negedge clk);
            if (mem_en) begin
                if (32'(mem_addr) == 32'h80) begin
                    order = {order, "D"};
                end else begin
                    order = {order, "I"};
                    if_cycles.push_back(cyc);
                end
            end
            step();
            cyc++;
        end
        step();
        if_req = 1'b0;
        d_req  = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        return ((32'h80 + 32'($urandom_range(0, 127))) << 2) | 32'($urandom_range(0, 3));
    endfunction

    // Reference: RAM as an array, arbitration from the grant history.
    typedef struct packed {
        bit is_d;
        bit if_waiting;
    } grant_t;

    task automatic run_random(input int ncyc);
        logic [31:0] model_mem [RAM_WORDS];
        grant_t      hist[$];
        bit          m_busy, m_owner_d, if_done, d_done, forced, dwin, wr;
        logic [31:0] m_exp, a;
        int          if_rise, widx;
        m_busy = 0; m_owner_d = 0; if_done = 0; d_done = 0; m_exp = '0; if_rise = 0;
        for (int i = 0; i < RAM_WORDS; i++) model_mem[i] = init_word(i);
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            if (if_done) begin if_done = 0; if_req = 1'b0; end
            if (d_done)  begin d_done  = 0; d_req  = 1'b0; end
            if (!if_req && $urandom_range(0, 99) < 50) begin
                if_req = 1'b1; if_addr = rand_addr(); if_rise = cyc;
            end
            if (!d_req && $urandom_range(0, 99) < 60) begin
                d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_addr = rand_addr();
                d_wdata = $urandom(); d_wstrb = 4'($urandom_range(0, 15));
            end
            @(negedge clk);
            if (!m_busy) begin
                if (if_req || d_req) begin
                    // Fetch must win once the last MAX grants were all data wins over it.
                    forced = (hist.size() >= MAX_DATA_BURST);
                    for (int i = 0; i < hist.size(); i++)
                        if (!(hist[i].is_d && hist[i].if_waiting)) forced = 0;
                    dwin = d_req && (!if_req || !forced);
                    wr   = dwin && d_we;
                    a    = dwin ? d_addr : if_addr;
                    widx = int'(a[9:2]);
                    chk("rnd_mem_en",    32'(mem_en), 32'd1);
                    chk("rnd_mem_addr",  32'(mem_addr), a >> 2);
                    chk("rnd_mem_we",    32'(mem_we), wr ? 32'(d_wstrb) : 32'd0);
                    chk("rnd_mem_wdata", mem_wdata, wr ? d_wdata : 32'd0);
                    m_exp = wr ? 32'd0 : model_mem[widx];
                    if (wr)
                        for (int b = 0; b < 4; b++)
                            if (d_wstrb[b]) model_mem[widx][8*b +: 8] = d_wdata[8*b +: 8];
                    hist.push_back('{is_d: dwin, if_waiting: if_req});
                    if (hist.size() > MAX_DATA_BURST) void'(hist.pop_front());
                    m_busy = 1; m_owner_d = dwin;
                end else begin
                    chk("rnd_idle_en", 32'(mem_en), 32'd0);
                end
            end else begin
                chk("rnd_resp_en", 32'(mem_en), 32'd0);
                chk("rnd_busy",    32'(busy), 32'd1);
                chk("rnd_if_ack",  32'(if_ack), m_owner_d ? 32'd0 : 32'd1);
                chk("rnd_d_ack",   32'(d_ack),  m_owner_d ? 32'd1 : 32'd0);
                chk("rnd_if_rdata", if_rdata, m_owner_d ? 32'd0 : m_exp);
                chk("rnd_d_rdata",  d_rdata,  m_owner_d ? m_exp : 32'd0);
                if (m_owner_d) begin
                    d_done = 1;
                end else begin
                    if_done = 1;
                    chk("rnd_fetch_wait_ok", 32'((cyc - if_rise) <= 2 * MAX_DATA_BURST + 2), 32'd1);
                end
                m_busy = 0;
            end
            step();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        step();
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'h000, 32'h0,         4'h0, 32'h0050_0093};
        vecs[1] = '{1'b0, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'hF, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h104, 32'h0,         4'h0, 32'hDEAD_BEEF};
        vecs[3] = '{1'b0, 1'b1, 32'h104, 32'h0000_1234, 4'h3, 32'h0};
        vecs[4] = '{1'b0, 1'b0, 32'h104, 32'h0,         4'h0, 32'hDEAD_1234};
        vecs[5] = '{1'b1, 1'b0, 32'h106, 32'h0,         4'h0, 32'hDEAD_1234};
        vecs[6] = '{1'b0, 1'b1, 32'h108, 32'hAABB_CCDD, 4'h8, 32'h0};
        vecs[7] = '{1'b0, 1'b0, 32'h10B, 32'h0,         4'h0, 32'hAA00_0042};

        // Reset held two cycles with both requesters active.
        ram_init = 1'b1; rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h8;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10C; d_wdata = '0; d_wstrb = '0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("reset_outputs_%0d", k),
                32'({|if_rdata, |d_rdata, if_ack, d_ack, busy, mem_en, |mem_we, |mem_addr, |mem_wdata}),
                32'd0);
            step();
        end
        rst = 1'b0; ram_init = 1'b0;
        @(negedge clk);
        chk("first_grant_en",   32'(mem_en), 32'd1);
        chk("first_grant_addr", 32'(mem_addr), 32'h43);
        step();
        @(negedge clk);
        chk("first_d_ack",  32'(d_ack), 32'd1);
        chk("first_if_ack", 32'(if_ack), 32'd0);
        chk("first_rdata",  d_rdata, 32'h1000_0043);
        step();
        if_req = 1'b0; d_req = 1'b0;
        step();

        for (int k = 0; k < 8; k++) do_txn(vecs[k], k);

        // Continuous contention.
        run_contention(10);
        chk_str("contention_order", order, "DDDDIDDDDI");
        chk("fetch_spacing",
            (if_cycles.size() == 2) ? 32'(if_cycles[1] - if_cycles[0]) : 32'hFFFF_FFFF, 32'd10);
        step();

        // Simultaneous single rise: data first, fetch right after.
        if_req = 1'b1; if_addr = 32'h0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h104;
        @(negedge clk);
        chk("simul_grant_d", 32'(mem_addr), 32'h41);
        step();
        @(negedge clk);
        chk("simul_d_ack",  32'(d_ack), 32'd1);
        chk("simul_if_ack", 32'(if_ack), 32'd0);
        chk("simul_d_rdata", d_rdata, 32'hDEAD_1234);
        step();
        d_req = 1'b0;
        @(negedge clk);
        chk("simul_grant_if_en",   32'(mem_en), 32'd1);
        chk("simul_grant_if_addr", 32'(mem_addr), 32'h0);
        step();
        @(negedge clk);
        chk("simul_if_ack2",  32'(if_ack), 32'd1);
        chk("simul_if_rdata", if_rdata, 32'h0050_0093);
        step();
        if_req = 1'b0;
        step();
        run_contention(5);
        chk_str("streak_cleared_order", order, "DDDDI");
        step();

        // Reset during the response cycle of a load.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10C;
        @(negedge clk);
        chk("rstmid_grant", 32'(mem_en), 32'd1);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_no_ack",  32'(d_ack), 32'd0);
        chk("rstmid_rdata",   d_rdata, 32'd0);
        chk("rstmid_no_en",   32'(mem_en), 32'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_idle",    32'(busy), 32'd0);
        chk("rstmid_regrant", 32'(mem_en), 32'd1);
        step();
        @(negedge clk);
        chk("rstmid_ack",   32'(d_ack), 32'd1);
        chk("rstmid_data",  d_rdata, 32'h1000_0043);
        step();
        d_req = 1'b0;
        step();

        run_random(600);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
